// File: rtl/cache_bank_ctrl_pkg.sv
// Shared constants, FSM encoding and types for the cache way
// bank access controller.
package cache_bank_ctrl_pkg;

  localparam int CACHE_INDEX_AW = 8;
  localparam int INDEX_AW = CACHE_INDEX_AW;
  localparam int BANK_NUM = 4;
  localparam int DATA_WIDTH = 32;
  localparam int BYTE_NUM = DATA_WIDTH / 8;
  localparam int RAM_NUM = BANK_NUM * BYTE_NUM;
  localparam int BANK_SEL_W = $clog2(BANK_NUM);

  localparam logic WR_PORT_ENABLE = 1'b1;
  localparam logic RD_PORT_ENABLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LD_ISSUE,
    LD_RESP,
    ST_ISSUE,
    RF_BEAT,
    RF_DONE
  } state_e;

  typedef logic [INDEX_AW-1:0] index_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [RAM_NUM-1:0] wr_en_t;
  typedef logic [BYTE_NUM-1:0] strb_t;
  typedef logic [BANK_SEL_W-1:0] bank_t;

  // Byte strobes placed onto the lanes of one bank.
  function automatic wr_en_t lane_mask(
    input strb_t strb,
    input bank_t bank
  );
    wr_en_t m;
    m = '0;
    m[BYTE_NUM-1:0] = strb;
    return m << (BYTE_NUM * int'(bank));
  endfunction

endpackage

// File: rtl/cache_bank_ctrl_if.sv
// Pipeline/memory-side request bundle of the bank controller:
// load, store and refill handshakes.
interface cache_bank_ctrl_if;
  import cache_bank_ctrl_pkg::*;

  logic   ld_valid_i;
  logic   ld_ready_o;
  index_t ld_index_i;
  bank_t  ld_bank_i;
  logic   ld_rsp_valid_o;
  word_t  ld_rsp_data_o;

  logic   st_valid_i;
  logic   st_ready_o;
  index_t st_index_i;
  bank_t  st_bank_i;
  strb_t  st_strb_i;
  word_t  st_data_i;

  logic   rf_start_i;
  index_t rf_index_i;
  logic   rf_valid_i;
  logic   rf_ready_o;
  word_t  rf_data_i;
  logic   rf_busy_o;
  logic   rf_done_o;

  modport slave (
    input  ld_valid_i, ld_index_i, ld_bank_i,
    output ld_ready_o, ld_rsp_valid_o,
    output ld_rsp_data_o,
    input  st_valid_i, st_index_i, st_bank_i,
    input  st_strb_i, st_data_i,
    output st_ready_o,
    input  rf_start_i, rf_index_i, rf_valid_i,
    input  rf_data_i,
    output rf_ready_o, rf_busy_o, rf_done_o
  );

  modport master (
    output ld_valid_i, ld_index_i, ld_bank_i,
    input  ld_ready_o, ld_rsp_valid_o,
    input  ld_rsp_data_o,
    output st_valid_i, st_index_i, st_bank_i,
    output st_strb_i, st_data_i,
    input  st_ready_o,
    output rf_start_i, rf_index_i, rf_valid_i,
    output rf_data_i,
    input  rf_ready_o, rf_busy_o, rf_done_o
  );

endinterface

// File: rtl/cache_bank_ctrl_bank_rd_mux.sv
// Word select across the bank read data bus.
module bank_rd_mux
  import cache_bank_ctrl_pkg::*;
(
  input  logic [BANK_NUM*DATA_WIDTH-1:0] rd_data,
  input  bank_t                          sel,
  output word_t                          word
);

  assign word = rd_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/cache_bank_ctrl.sv
// Serialises refill, store and load traffic onto the four data
// banks of one cache way and returns load data.
module cache_bank_ctrl
  import cache_bank_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  cache_bank_ctrl_if.slave              req,
  output index_t                        bank_index_o,
  output wr_en_t                        bank_wr_en_o,
  output word_t                         bank_wr_data_o,
  input  logic [BANK_NUM*DATA_WIDTH-1:0] bank_rd_data_i
);

  localparam wr_en_t WR_GATE = {RAM_NUM{WR_PORT_ENABLE}};
  localparam bank_t LAST_BEAT = bank_t'(BANK_NUM - 1);

  state_e state;
  logic   acc_en;
  bank_t  ld_bank_q;
  bank_t  rf_cnt;
  index_t rf_index_q;
  word_t  rsp_hold;
  word_t  mux_word;
  word_t  ld_word;
  logic   rf_busy_q;
  logic   rf_done_q;
  logic   idle;
  logic   take_rf;
  logic   take_st;
  logic   take_ld;
  logic   rf_beat;

  bank_rd_mux u_rd_mux (
    .rd_data (bank_rd_data_i),
    .sel     (ld_bank_q),
    .word    (mux_word)
  );

  assign ld_word = RD_PORT_ENABLE ? mux_word : '0;

  // acc_en keeps the ready outputs low while reset is held.
  assign idle = acc_en && (state == IDLE);
  assign req.st_ready_o = idle && !req.rf_start_i;
  assign req.ld_ready_o = idle && !req.rf_start_i
                          && !req.st_valid_i;

  assign take_rf = idle && req.rf_start_i;
  assign take_st = req.st_valid_i && req.st_ready_o;
  assign take_ld = req.ld_valid_i && req.ld_ready_o;

  assign req.rf_ready_o = (state == RF_BEAT);
  assign rf_beat = req.rf_valid_i && req.rf_ready_o;

  assign req.rf_busy_o = rf_busy_q;
  assign req.rf_done_o = rf_done_q;

  // Bank data lands one cycle after the index, i.e. in LD_RESP.
  assign req.ld_rsp_valid_o = (state == LD_RESP);
  assign req.ld_rsp_data_o  = (state == LD_RESP) ? ld_word
                                                 : rsp_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc_en         <= 1'b0;
      ld_bank_q      <= '0;
      rf_cnt         <= '0;
      rf_index_q     <= '0;
      rsp_hold       <= '0;
      rf_busy_q      <= 1'b0;
      rf_done_q      <= 1'b0;
      bank_index_o   <= '0;
      bank_wr_en_o   <= '0;
      bank_wr_data_o <= '0;
    end else begin
      acc_en       <= 1'b1;
      bank_wr_en_o <= '0;
      rf_done_q    <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            take_rf: begin
              state      <= RF_BEAT;
              rf_index_q <= req.rf_index_i;
              rf_cnt     <= '0;
              rf_busy_q  <= 1'b1;
            end
            take_st: begin
              state          <= ST_ISSUE;
              bank_index_o   <= req.st_index_i;
              bank_wr_data_o <= req.st_data_i;
              bank_wr_en_o   <= WR_GATE
                & lane_mask(req.st_strb_i,
                            req.st_bank_i);
            end
            take_ld: begin
              state        <= LD_ISSUE;
              bank_index_o <= req.ld_index_i;
              ld_bank_q    <= req.ld_bank_i;
            end
            default: ;
          endcase
        end
        LD_ISSUE: state <= LD_RESP;
        LD_RESP: begin
          state    <= IDLE;
          rsp_hold <= ld_word;
        end
        ST_ISSUE: state <= IDLE;
        RF_BEAT: begin
          if (rf_beat) begin
            bank_index_o   <= rf_index_q;
            bank_wr_data_o <= req.rf_data_i;
            bank_wr_en_o   <= WR_GATE
              & lane_mask('1, rf_cnt);
            rf_cnt         <= rf_cnt + 1'b1;
            if (rf_cnt == LAST_BEAT) begin
              state     <= RF_DONE;
              rf_done_q <= 1'b1;
            end
          end
        end
        RF_DONE: begin
          state     <= IDLE;
          rf_busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_bank_ctrl.md
Name: cache_bank_ctrl

Overview:
- Access controller directly upstream of the four data banks of one cache way.
- Serialises three request types onto the banks' shared index, byte write-enables and write data:
  - line refill from memory (4 beats);
  - byte-strobed stores;
  - loads.
- Selects the loaded word from the banks' 1-cycle-latency read data and returns it to the pipeline.

Parameters:
- INDEX_AW, 8, cache index width (256 lines).
- BANK_NUM, 4, banks per line (one 32-bit word each).
- DATA_WIDTH, 32, word width; each bank has DATA_WIDTH/8 byte RAMs.

Ports:
- clk  in  1  single clock for controller and banks
- rst_n  in  1  asynchronous active-low reset
- ld_valid_i  in  1  load request valid
- ld_ready_o  out  1  load request accepted when valid&ready
- ld_index_i  in  INDEX_AW  load line index
- ld_bank_i  in  2  load word select (addr[3:2])
- ld_rsp_valid_o  out  1  load data valid, 1-cycle pulse
- ld_rsp_data_o  out  DATA_WIDTH  load data
- st_valid_i  in  1  store request valid
- st_ready_o  out  1  store accepted when valid&ready
- st_index_i  in  INDEX_AW  store line index
- st_bank_i  in  2  store word select
- st_strb_i  in  4  byte strobes
- st_data_i  in  DATA_WIDTH  store data
- rf_start_i  in  1  refill start pulse
- rf_index_i  in  INDEX_AW  refill line index, sampled on start
- rf_valid_i  in  1  refill beat valid
- rf_ready_o  out  1  refill beat accepted when valid&ready
- rf_data_i  in  DATA_WIDTH  refill word; beat k goes to bank k
- rf_busy_o  out  1  refill in progress
- rf_done_o  out  1  pulse, last refill write presented
- bank_index_o  out  INDEX_AW  shared bank read/write index (registered)
- bank_wr_en_o  out  BANK_NUM*4  per-bank byte write enables; bank k uses bits [4k+3:4k] (registered)
- bank_wr_data_o  out  DATA_WIDTH  shared write data (registered)
- bank_rd_data_i  in  BANK_NUM*DATA_WIDTH  bank read data; bank k uses [32k+31:32k]

Behaviour:
- Reset (async, rst_n=0): state IDLE, beat counter 0.
  - All outputs 0: bank_index_o, bank_wr_en_o, bank_wr_data_o, ld_rsp_valid_o, ld_rsp_data_o, rf_busy_o, rf_done_o, ready outputs.
- FSM states: IDLE, LD_ISSUE, LD_RESP, ST_ISSUE, RF_BEAT, RF_DONE.
- Requests are only accepted in IDLE, one per cycle. Priority: rf_start_i > store > load.
  - st_ready_o = IDLE & !rf_start_i.
  - ld_ready_o = IDLE & !rf_start_i & !st_valid_i.
- Load, accepted cycle T:
  - T+1 (LD_ISSUE): bank_index_o = ld_index, bank_wr_en_o = 0.
  - T+2 (LD_RESP): ld_rsp_valid_o = 1, ld_rsp_data_o = bank_rd_data_i word[ld_bank latched at T]. Return to IDLE.
  - ld_rsp_data_o holds its value after the pulse.
- Store, accepted cycle T:
  - T+1 (ST_ISSUE): bank_index_o = st_index, bank_wr_data_o = st_data, bank_wr_en_o = st_strb << 4*st_bank.
  - The RAM writes at the end of T+1; T+2 is IDLE with bank_wr_en_o = 0.
  - st_strb = 0 still consumes the slot and writes nothing.
- Refill:
  - rf_start_i in IDLE latches rf_index, sets rf_busy_o, enters RF_BEAT with counter 0.
  - In RF_BEAT rf_ready_o = 1. Each accepted beat registers: bank_wr_en_o = 4'hF << 4*cnt, bank_wr_data_o = rf_data_i, bank_index_o = rf_index. cnt then increments.
  - Cycles without a beat drive bank_wr_en_o = 0.
  - After beat 3: RF_DONE for one cycle. rf_done_o = 1; the last write is presented this cycle; rf_ready_o = 0.
  - rf_busy_o clears on entry to IDLE.
- Ignored inputs:
  - rf_valid_i outside RF_BEAT.
  - rf_start_i outside IDLE.
- Hazards:
  - Read-after-write at the same index is safe without forwarding: the minimum turnaround after a store or refill places the read after the write edge.
- Reset mid-refill: immediate return to IDLE. The partial line is left in the RAM; invalidating it is the tag logic's responsibility.

Decomposition:
- Shared defines file: CACHE_INDEX_AW, RAM_NUM, BANK_NUM, DATA_WIDTH, FSM state encodings, WR_PORT_ENABLE/RD_PORT_ENABLE.
- One natural sub-module: bank_rd_mux, the combinational BANK_NUM:1 word select of bank_rd_data_i. Everything else stays in cache_bank_ctrl.

Test Plan:
- Reset mid-refill: assert rst_n=0 after beat 1 -> all outputs 0 immediately. After release, a load of index 0x10 bank 0 returns the beat-0 data.
- Refill index 0x10 with beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 (gap of 2 idle cycles before beat 2):
  - bank_wr_en_o sequence is 0x000F, 0x00F0, (0 during the gap), 0x0F00, 0xF000;
  - rf_done_o pulses once, in the cycle after beat 3.
- Load index 0x10 bank 2 after that refill -> ld_rsp_valid_o exactly 2 cycles after accept, data 0x33333333.
- Store index 0x10 bank 1, strb 4'b0101, data 0xAABBCCDD -> bank_wr_en_o = 0x0050 for one cycle. A following load of bank 1 returns 0x22BB22DD.
- Same-cycle rf_start_i + st_valid_i + ld_valid_i in IDLE:
  - refill is taken; st_ready_o = ld_ready_o = 0;
  - store is accepted in the first IDLE after RF_DONE, load in the cycle after its ST_ISSUE.
- Store to index 0x20 immediately followed by a load of the same word -> load returns the stored data (no stale read).
